// File: rtl/inter_switch_sched.sv
`default_nettype none
// ============================================================================
// Module   : inter_switch_sched
// Brief    : Route-command scheduler for the inter-switch crossbar; holds ctrl
//            stable for a whole transfer and parks the switch when idle.
// Revision : 1.0  initial release
// ============================================================================
module inter_switch_sched #(
    parameter int         BEAT_W      = 16,
    parameter int         TIMEOUT_CYC = 4096,
    parameter logic [5:0] PARK_CTRL   = 6'h07
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W+5:0] s_cmd_tdata,
    input  logic              s_cmd_tvalid,
    output logic              s_cmd_tready,
    output logic [5:0]        ctrl,
    input  logic [4:0]        in_hs_valid,
    input  logic [4:0]        in_hs_ready,
    input  logic [7:0]        out_hs_valid,
    input  logic [7:0]        out_hs_ready,
    output logic              busy,
    output logic              done,
    output logic              err_cmd,
    output logic              err_timeout,
    input  logic              err_clr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int                     c_STALL_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_STALL_W-1:0]   c_STALL_LAST = c_STALL_W'(TIMEOUT_CYC - 1);
    localparam logic [c_STALL_W-1:0]   c_STALL_ONE  = 1;
    localparam logic [BEAT_W-1:0]      c_BEAT_ONE   = 1;

    // Sink beats per 1536-bit input beat, by sink width
    function automatic logic [3:0] f_ratio(input logic [2:0] sel);
        case (sel)
            3'd4, 3'd3: f_ratio = 4'd12;
            3'd0:       f_ratio = 4'd6;
            default:    f_ratio = 4'd1;
        endcase
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_out_sel;
    logic [2:0]            r_in_sel;
    logic [BEAT_W-1:0]     r_beats;
    logic [BEAT_W+3:0]     r_out_target;
    logic [BEAT_W-1:0]     r_in_cnt;
    logic [BEAT_W+3:0]     r_out_cnt;
    logic [c_STALL_W-1:0]  r_stall_cnt;

    logic [2:0]            w_cmd_out_sel;
    logic [2:0]            w_cmd_in_sel;
    logic [BEAT_W-1:0]     w_cmd_beats;
    logic                  w_accept;
    logic [7:0]            w_in_vec;
    logic [7:0]            w_out_vec;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_any_fire;
    logic                  w_in_last;
    logic [BEAT_W+3:0]     w_out_next;
    logic                  w_stall_hit;

    logic                  w_load;
    logic                  w_cmd_bad;
    logic                  w_setup;
    logic                  w_src_off;
    logic                  w_park;
    logic                  w_timeout;

    assign w_cmd_out_sel = s_cmd_tdata[BEAT_W+5:BEAT_W+3];
    assign w_cmd_in_sel  = s_cmd_tdata[BEAT_W+2:BEAT_W];
    assign w_cmd_beats   = s_cmd_tdata[BEAT_W-1:0];

    assign s_cmd_tready = !rst && (r_state == S_IDLE);
    assign busy         = !rst && (r_state != S_IDLE);
    assign done         = !rst && (r_state == S_DONE);
    assign w_accept     = s_cmd_tvalid && s_cmd_tready;

    // Padded to 8 so any 3-bit select indexes a real bit
    assign w_in_vec   = {3'b000, in_hs_valid & in_hs_ready};
    assign w_out_vec  = out_hs_valid & out_hs_ready;
    assign w_in_fire  = (r_state == S_RUN) && w_in_vec[r_in_sel];
    assign w_out_fire = ((r_state == S_RUN) || (r_state == S_DRAIN)) && w_out_vec[r_out_sel];
    assign w_any_fire = w_in_fire || w_out_fire;
    assign w_in_last  = ((r_in_cnt + c_BEAT_ONE) == r_beats);
    assign w_out_next = r_out_cnt + {{(BEAT_W+3){1'b0}}, w_out_fire};
    assign w_stall_hit = (TIMEOUT_CYC != 0) && !w_any_fire && (r_stall_cnt == c_STALL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cmd_bad   = 1'b0;
        w_setup     = 1'b0;
        w_src_off   = 1'b0;
        w_park      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_cmd_in_sel > 3'd4) begin
                        w_cmd_bad = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = (w_cmd_beats == '0) ? S_DONE : S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                w_setup     = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_in_fire && w_in_last) begin
                    w_src_off   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end else if (w_stall_hit) begin
                    w_timeout   = 1'b1;
                    w_park      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_out_next >= r_out_target) begin
                    w_park      = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_stall_hit) begin
                    w_timeout   = 1'b1;
                    w_park      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl         <= PARK_CTRL;
            r_out_sel    <= '0;
            r_in_sel     <= '0;
            r_beats      <= '0;
            r_out_target <= '0;
            r_in_cnt     <= '0;
            r_out_cnt    <= '0;
            r_stall_cnt  <= '0;
            err_cmd      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_sel    <= w_cmd_out_sel;
                r_in_sel     <= w_cmd_in_sel;
                r_beats      <= w_cmd_beats;
                r_out_target <= {4'b0000, w_cmd_beats} * {{BEAT_W{1'b0}}, f_ratio(w_cmd_out_sel)};
            end

            if (w_setup) begin
                ctrl        <= {r_out_sel, r_in_sel};
                r_in_cnt    <= '0;
                r_out_cnt   <= '0;
                r_stall_cnt <= '0;
            end else if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
                if (w_in_fire) begin
                    r_in_cnt <= r_in_cnt + c_BEAT_ONE;
                end
                r_out_cnt   <= w_out_next;
                r_stall_cnt <= w_any_fire ? '0 : (r_stall_cnt + c_STALL_ONE);
            end

            // Source is cut on the final input beat so no extra beat slips through
            if (w_src_off) begin
                ctrl[2:0] <= 3'd7;
            end
            if (w_park) begin
                ctrl <= PARK_CTRL;
            end

            if (w_cmd_bad) begin
                err_cmd <= 1'b1;
            end else if (err_clr) begin
                err_cmd <= 1'b0;
            end
            if (w_timeout) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inter_switch_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_inter_switch_sched
// Brief    : Directed bench for inter_switch_sched with a small switch model.
// Revision : 1.0  initial release
// ============================================================================
module tb_inter_switch_sched;

    localparam int BEAT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [BEAT_W+5:0] s_cmd_tdata;
    logic              s_cmd_tvalid;
    logic              s_cmd_tready;
    logic [5:0]        ctrl;
    logic [4:0]        in_hs_valid;
    logic [4:0]        in_hs_ready;
    logic [7:0]        out_hs_valid;
    logic [7:0]        out_hs_ready;
    logic              busy;
    logic              done;
    logic              err_cmd;
    logic              err_timeout;
    logic              err_clr;

    inter_switch_sched #(
        .BEAT_W      (BEAT_W),
        .TIMEOUT_CYC (16),
        .PARK_CTRL   (6'h07)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .s_cmd_tdata  (s_cmd_tdata),
        .s_cmd_tvalid (s_cmd_tvalid),
        .s_cmd_tready (s_cmd_tready),
        .ctrl         (ctrl),
        .in_hs_valid  (in_hs_valid),
        .in_hs_ready  (in_hs_ready),
        .out_hs_valid (out_hs_valid),
        .out_hs_ready (out_hs_ready),
        .busy         (busy),
        .done         (done),
        .err_cmd      (err_cmd),
        .err_timeout  (err_timeout),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Switch model: source always offers data when routed, sink data appears
    // as credits (ratio sink beats per input beat).
    logic       cnt_clr = 1'b0;
    logic [1:0] snk_mode = 2'd0;
    int         ratio = 1;
    int         credits = 0;
    int         in_fires = 0;
    int         out_fires = 0;
    int         done_cnt = 0;
    int         cyc = 0;
    int         last_fire = 0;
    logic       snk_rdy;
    logic       tb_in_f;
    logic       tb_out_f;

    always_comb begin
        case (snk_mode)
            2'd0:    snk_rdy = 1'b1;
            2'd1:    snk_rdy = cyc[0];
            2'd2:    snk_rdy = (out_fires < 1);
            default: snk_rdy = 1'b0;
        endcase
    end

    always_comb begin
        in_hs_valid  = '0;
        in_hs_ready  = '0;
        out_hs_valid = '0;
        out_hs_ready = '0;
        for (int k = 0; k < 5; k++) begin
            if (ctrl[2:0] == 3'(k)) begin
                in_hs_valid[k] = 1'b1;
                in_hs_ready[k] = 1'b1;
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (ctrl[5:3] == 3'(k)) begin
                out_hs_valid[k] = (credits > 0);
                out_hs_ready[k] = snk_rdy;
            end
        end
    end

    assign tb_in_f  = |(in_hs_valid & in_hs_ready);
    assign tb_out_f = |(out_hs_valid & out_hs_ready);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cnt_clr) begin
            credits   <= 0;
            in_fires  <= 0;
            out_fires <= 0;
            done_cnt  <= 0;
        end else begin
            credits <= credits + (tb_in_f ? ratio : 0) - (tb_out_f ? 1 : 0);
            if (tb_in_f)  in_fires  <= in_fires + 1;
            if (tb_out_f) out_fires <= out_fires + 1;
            if (done)     done_cnt  <= done_cnt + 1;
            if (tb_in_f || tb_out_f) last_fire <= cyc + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model(input int r, input logic [1:0] mode);
        ratio    = r;
        snk_mode = mode;
        cnt_clr  = 1'b1;
        tick();
        cnt_clr  = 1'b0;
    endtask

    task automatic send(input logic [2:0] o, input logic [2:0] i, input logic [BEAT_W-1:0] b);
        s_cmd_tdata  = {o, i, b};
        s_cmd_tvalid = 1'b1;
        check("cmd_ready", {31'd0, s_cmd_tready}, 32'd1);
        tick();
        s_cmd_tvalid = 1'b0;
    endtask

    task automatic wait_done(input int max, input int n_in, output bit seen,
                             output int outs, output logic [5:0] ctrl_last_in);
        bit got_in;
        got_in       = 1'b0;
        seen         = 1'b0;
        outs         = -1;
        ctrl_last_in = 6'h00;
        for (int i = 0; i < max && !seen; i++) begin
            tick();
            if (!got_in && in_fires == n_in) begin
                got_in       = 1'b1;
                ctrl_last_in = ctrl;
            end
            if (done) begin
                seen = 1'b1;
                outs = out_fires;
            end
        end
    endtask

    bit         seen;
    int         outs;
    logic [5:0] c_last;

    initial begin
        rst          = 1'b1;
        s_cmd_tdata  = '0;
        s_cmd_tvalid = 1'b0;
        err_clr      = 1'b0;
        cnt_clr      = 1'b1;
        tick();
        tick();
        check("rst_ctrl",   {26'd0, ctrl}, 32'h07);
        check("rst_busy",   {31'd0, busy}, 32'd0);
        check("rst_done",   {31'd0, done}, 32'd0);
        check("rst_errs",   {30'd0, err_cmd, err_timeout}, 32'd0);
        check("rst_tready", {31'd0, s_cmd_tready}, 32'd0);
        rst     = 1'b0;
        cnt_clr = 1'b0;
        #1;
        check("idle_tready", {31'd0, s_cmd_tready}, 32'd1);

        // Basic route e->a, R=1
        clear_model(1, 2'd0);
        send(3'd7, 3'd4, 16'd3);
        check("t1_setup_busy", {31'd0, busy}, 32'd1);
        check("t1_setup_ctrl", {26'd0, ctrl}, 32'h07);
        check("t1_setup_rdy",  {31'd0, s_cmd_tready}, 32'd0);
        tick();
        check("t1_ctrl_T2", {26'd0, ctrl}, 32'h3C);
        wait_done(50, 3, seen, outs, c_last);
        check("t1_done_seen", {31'd0, seen}, 32'd1);
        check("t1_outs",      outs, 32'd3);
        check("t1_ctrl_last", {26'd0, c_last}, 32'h3F);
        check("t1_park",      {26'd0, ctrl}, 32'h07);
        tick();
        check("t1_done_cnt", done_cnt, 32'd1);
        check("t1_ins",      in_fires, 32'd3);
        check("t1_idle",     {30'd0, busy, done}, 32'd0);

        // 128-bit sink: 2 input beats -> 24 sink beats
        clear_model(12, 2'd0);
        send(3'd4, 3'd2, 16'd2);
        tick();
        check("t2_ctrl_T2", {26'd0, ctrl}, 32'h22);
        wait_done(100, 2, seen, outs, c_last);
        check("t2_done_seen", {31'd0, seen}, 32'd1);
        check("t2_ctrl_last", {26'd0, c_last}, 32'h27);
        check("t2_outs",      outs, 32'd24);
        tick();
        check("t2_ins",      in_fires, 32'd2);
        check("t2_done_cnt", done_cnt, 32'd1);

        // 256-bit sink, ready toggling
        clear_model(6, 2'd1);
        send(3'd0, 3'd0, 16'd5);
        tick();
        check("t3_ctrl_T2", {26'd0, ctrl}, 32'h00);
        wait_done(200, 5, seen, outs, c_last);
        check("t3_done_seen", {31'd0, seen}, 32'd1);
        check("t3_outs",      outs, 32'd30);
        check("t3_ctrl_last", {26'd0, c_last}, 32'h07);
        tick();
        tick();
        check("t3_ins",      in_fires, 32'd5);
        check("t3_done_cnt", done_cnt, 32'd1);

        // Bad source code
        clear_model(1, 2'd0);
        send(3'd1, 3'd6, 16'd3);
        check("t4_err_cmd", {31'd0, err_cmd}, 32'd1);
        check("t4_busy",    {31'd0, busy}, 32'd0);
        check("t4_ctrl",    {26'd0, ctrl}, 32'h07);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t4_err_clr", {31'd0, err_cmd}, 32'd0);
        err_clr = 1'b1;
        send(3'd1, 3'd5, 16'd3);
        err_clr = 1'b0;
        check("t4_err_wins", {31'd0, err_cmd}, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Zero-beat command completes without touching ctrl
        send(3'd7, 3'd1, 16'd0);
        check("t5_done",  {31'd0, done}, 32'd1);
        check("t5_ctrl",  {26'd0, ctrl}, 32'h07);
        tick();
        check("t5_idle",  {30'd0, busy, done}, 32'd0);

        // Stall timeout: sink accepts one beat then stalls
        clear_model(1, 2'd2);
        send(3'd7, 3'd4, 16'd4);
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            seen = err_timeout;
        end
        check("t6_timeout",   {31'd0, seen}, 32'd1);
        check("t6_idle_cyc",  cyc - last_fire, 32'd16);
        check("t6_ctrl",      {26'd0, ctrl}, 32'h07);
        check("t6_busy",      {31'd0, busy}, 32'd0);
        check("t6_no_done",   done_cnt, 32'd0);
        check("t6_ins",       in_fires, 32'd4);
        check("t6_outs",      out_fires, 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t6_clr", {31'd0, err_timeout}, 32'd0);

        // Reset mid-transfer
        clear_model(12, 2'd0);
        send(3'd4, 3'd3, 16'd8);
        for (int i = 0; i < 10 && in_fires < 2; i++) tick();
        check("t7_in2", in_fires, 32'd2);
        rst     = 1'b1;
        cnt_clr = 1'b1;
        tick();
        check("t7_ctrl", {26'd0, ctrl}, 32'h07);
        check("t7_busy", {31'd0, busy}, 32'd0);
        rst     = 1'b0;
        cnt_clr = 1'b0;
        #1;
        check("t7_tready", {31'd0, s_cmd_tready}, 32'd1);
        clear_model(1, 2'd0);
        send(3'd7, 3'd4, 16'd3);
        tick();
        check("t7b_ctrl_T2", {26'd0, ctrl}, 32'h3C);
        wait_done(50, 3, seen, outs, c_last);
        check("t7b_done", {31'd0, seen}, 32'd1);
        check("t7b_outs", outs, 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
